// File: rtl/alu_6bit.sv
// Purpose: 6-bit unsigned ALU, 16 opcodes, result truncated mod 64.
// Latency: 1 cycle from sampled sel/A/B to X; synchronous reset clears X.
// Backpressure: none; one operation accepted every cycle, no handshake.
module alu_6bit (
  input  logic       clk,
  input  logic       rst,
  input  logic [3:0] sel,
  input  logic [5:0] A,
  input  logic [5:0] B,
  output logic [5:0] X
);

  // Opcode encodings, named so the decode below reads as the operation list.
  typedef enum logic [3:0] {
    OP_ZERO = 4'b0000,
    OP_PASS_A = 4'b0001,
    OP_PASS_B = 4'b0010,
    OP_MAX = 4'b0011,
    OP_MIN = 4'b0100,
    OP_ADD = 4'b0101,
    OP_SUB = 4'b0110,
    OP_AND = 4'b0111,
    OP_OR = 4'b1000,
    OP_XOR = 4'b1001,
    OP_NOT_A = 4'b1010,
    OP_SHL = 4'b1011,
    OP_SHR = 4'b1100,
    OP_INC = 4'b1101,
    OP_DEC = 4'b1110,
    OP_LT = 4'b1111
  } op_e;

  logic [5:0] result;
  logic       a_lt_b;

  // Single shared unsigned comparator feeds max, min and set-less-than.
  assign a_lt_b = (A < B);

  // Combinational result decode; every opcode maps to a defined value.
  always_comb begin
    result = 6'b000000;
    case (sel)
      OP_ZERO:   result = 6'b000000;
      OP_PASS_A: result = A;
      OP_PASS_B: result = B;
      OP_MAX:    result = a_lt_b ? B : A;   // tie returns A (== B)
      OP_MIN:    result = a_lt_b ? A : B;
      OP_ADD:    result = A + B;            // carry out dropped
      OP_SUB:    result = A - B;            // borrow dropped, wraps
      OP_AND:    result = A & B;
      OP_OR:     result = A | B;
      OP_XOR:    result = A ^ B;
      OP_NOT_A:  result = ~A;
      OP_SHL:    result = {A[4:0], 1'b0};
      OP_SHR:    result = {1'b0, A[5:1]};
      OP_INC:    result = A + 6'd1;
      OP_DEC:    result = A - 6'd1;
      OP_LT:     result = a_lt_b ? 6'b000001 : 6'b000000;
      default:   result = 6'b000000;
    endcase
  end

  // Result register; reset wins over the operation sampled at the same edge.
  always_ff @(posedge clk) begin
    if (rst) begin
      X <= 6'b000000;
    end else begin
      X <= result;
    end
  end

endmodule

// File: tb/tb_alu_6bit.sv
// Purpose: self-checking bench for alu_6bit (vector table + scoreboard queue).
// Latency: expects X one edge after inputs are driven.
// Backpressure: none; inputs change on the falling edge, X sampled #1 after rising.
module tb_alu_6bit;

  logic       clk;
  logic       rst;
  logic [3:0] sel;
  logic [5:0] A;
  logic [5:0] B;
  logic [5:0] X;

  int tests_run = 0;
  int tests_failed = 0;

  typedef struct {
    logic       rst;
    logic [3:0] sel;
    logic [5:0] a;
    logic [5:0] b;
    logic [5:0] x;
    string      name;
  } vec_t;

  typedef struct {
    logic [5:0] x;
    string      name;
  } exp_t;

  localparam int NVEC = 25;
  vec_t vecs [NVEC];
  exp_t sb [$];

  alu_6bit dut (
    .clk(clk),
    .rst(rst),
    .sel(sel),
    .A(A),
    .B(B),
    .X(X)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference written in integer arithmetic, independent of bit-level decode.
  function automatic logic [5:0] model(input logic [3:0] s, input logic [5:0] a, input logic [5:0] b);
    int ia, ib, r;
    ia = int'(a);
    ib = int'(b);
    case (s)
      4'd0:  r = 0;
      4'd1:  r = ia;
      4'd2:  r = ib;
      4'd3:  r = (ia >= ib) ? ia : ib;
      4'd4:  r = (ia <= ib) ? ia : ib;
      4'd5:  r = (ia + ib) % 64;
      4'd6:  r = (ia - ib + 64) % 64;
      4'd7:  r = ia & ib;
      4'd8:  r = ia | ib;
      4'd9:  r = ia ^ ib;
      4'd10: r = 63 - ia;
      4'd11: r = (ia * 2) % 64;
      4'd12: r = ia / 2;
      4'd13: r = (ia + 1) % 64;
      4'd14: r = (ia + 63) % 64;
      default: r = (ia < ib) ? 1 : 0;
    endcase
    return r[5:0];
  endfunction

  // Drive one cycle of stimulus on the falling edge and queue its expectation.
  task automatic drive(input logic r, input logic [3:0] s, input logic [5:0] a,
                       input logic [5:0] b, input logic [5:0] x, input string nm);
    exp_t e;
    @(negedge clk);
    rst = r;
    sel = s;
    A = a;
    B = b;
    e.x = x;
    e.name = nm;
    sb.push_back(e);
  endtask

  // Wait for the capturing edge and compare X against the oldest expectation.
  task automatic check_next();
    exp_t e;
    @(posedge clk);
    #1;
    if (sb.size() == 0) begin
      tests_run++;
      tests_failed++;
      $display("FAIL scoreboard_empty: X=%b with no expectation queued", X);
    end else begin
      e = sb.pop_front();
      tests_run++;
      if (X !== e.x) begin
        tests_failed++;
        $display("FAIL %s: X=%b expected %b", e.name, X, e.x);
      end
    end
  endtask

  task automatic step(input logic r, input logic [3:0] s, input logic [5:0] a,
                      input logic [5:0] b, input logic [5:0] x, input string nm);
    drive(r, s, a, b, x, nm);
    check_next();
  endtask

  initial begin
    rst = 1'b1;
    sel = 4'b0101;
    A = 6'b111111;
    B = 6'b111111;

    vecs[0]  = '{1'b1, 4'b0101, 6'b111111, 6'b111111, 6'b000000, "reset_c1"};
    vecs[1]  = '{1'b1, 4'b0101, 6'b111111, 6'b111111, 6'b000000, "reset_c2"};
    vecs[2]  = '{1'b0, 4'b0101, 6'b111111, 6'b111111, 6'b111110, "reset_release_add"};
    vecs[3]  = '{1'b0, 4'b0011, 6'b000000, 6'b000000, 6'b000000, "max_zero"};
    vecs[4]  = '{1'b0, 4'b0011, 6'b000100, 6'b000010, 6'b000100, "max_a_gt"};
    vecs[5]  = '{1'b0, 4'b0011, 6'b000010, 6'b000100, 6'b000100, "max_b_gt"};
    vecs[6]  = '{1'b0, 4'b0011, 6'b110000, 6'b011000, 6'b110000, "max_a_msb"};
    vecs[7]  = '{1'b0, 4'b0011, 6'b011000, 6'b110000, 6'b110000, "max_b_msb"};
    vecs[8]  = '{1'b0, 4'b0011, 6'b111111, 6'b111111, 6'b111111, "max_tie_ones"};
    vecs[9]  = '{1'b0, 4'b0101, 6'b110000, 6'b011000, 6'b001000, "add_wrap"};
    vecs[10] = '{1'b0, 4'b0110, 6'b000010, 6'b000100, 6'b111110, "sub_wrap"};
    vecs[11] = '{1'b0, 4'b1101, 6'b111111, 6'b000000, 6'b000000, "inc_wrap"};
    vecs[12] = '{1'b0, 4'b1110, 6'b000000, 6'b000000, 6'b111111, "dec_wrap"};
    vecs[13] = '{1'b0, 4'b0111, 6'b110000, 6'b011000, 6'b010000, "and"};
    vecs[14] = '{1'b0, 4'b1000, 6'b110000, 6'b011000, 6'b111000, "or"};
    vecs[15] = '{1'b0, 4'b1001, 6'b110000, 6'b011000, 6'b101000, "xor"};
    vecs[16] = '{1'b0, 4'b1010, 6'b110000, 6'b011000, 6'b001111, "not_a"};
    vecs[17] = '{1'b0, 4'b1011, 6'b110000, 6'b011000, 6'b100000, "shl"};
    vecs[18] = '{1'b0, 4'b1100, 6'b110000, 6'b011000, 6'b011000, "shr"};
    vecs[19] = '{1'b0, 4'b0000, 6'b101010, 6'b010101, 6'b000000, "zero"};
    vecs[20] = '{1'b0, 4'b0001, 6'b000100, 6'b111111, 6'b000100, "pass_a"};
    vecs[21] = '{1'b0, 4'b0010, 6'b111111, 6'b000010, 6'b000010, "pass_b"};
    vecs[22] = '{1'b0, 4'b0100, 6'b000100, 6'b000010, 6'b000010, "min"};
    vecs[23] = '{1'b0, 4'b1111, 6'b000010, 6'b000100, 6'b000001, "lt_true"};
    vecs[24] = '{1'b0, 4'b1111, 6'b000100, 6'b000100, 6'b000000, "lt_equal"};

    for (int i = 0; i < NVEC; i++) begin
      step(vecs[i].rst, vecs[i].sel, vecs[i].a, vecs[i].b, vecs[i].x, vecs[i].name);
    end

    // Input change between edges must not reach X until the next edge.
    step(1'b0, 4'b0001, 6'b001010, 6'b000000, 6'b001010, "hold_load");
    #2;
    A = 6'b010100;
    #1;
    tests_run++;
    if (X !== 6'b001010) begin
      tests_failed++;
      $display("FAIL hold_between_edges: X=%b expected %b", X, 6'b001010);
    end
    begin
      exp_t e;
      e.x = 6'b010100;
      e.name = "hold_next_edge";
      sb.push_back(e);
    end
    check_next();

    // One-edge reset in the middle of a pass-A stream.
    step(1'b0, 4'b0001, 6'b000101, 6'b000000, 6'b000101, "stream_a0");
    step(1'b1, 4'b0001, 6'b000110, 6'b000000, 6'b000000, "stream_rst");
    step(1'b0, 4'b0001, 6'b000111, 6'b000000, 6'b000111, "stream_resume1");
    step(1'b0, 4'b0001, 6'b101011, 6'b000000, 6'b101011, "stream_resume2");

    // Back-to-back random operations against the integer model.
    for (int i = 0; i < 48; i++) begin
      logic [3:0] s;
      logic [5:0] a, b;
      s = 4'($urandom_range(0, 15));
      a = 6'($urandom_range(0, 63));
      b = 6'($urandom_range(0, 63));
      step(1'b0, s, a, b, model(s, a, b), "random");
    end

    if (sb.size() != 0) begin
      tests_run++;
      tests_failed++;
      $display("FAIL scoreboard_leftover: %0d entries remain, expected 0", sb.size());
    end

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
